// File: rtl/uart_rx_v1_pkg.sv
// uart_rx_v1 shared constants and types.
// Baud divisors, oversample ratio, FSM states.
package uart_rx_v1_pkg;

  localparam int UART_DIV_38400  = 52;
  localparam int UART_DIV_57600  = 35;
  localparam int UART_DIV_115200 = 17;
  localparam int UART_OVS        = 16;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  function automatic logic [5:0] div_of(input logic [1:0] sel);
    logic [5:0] d;
    case (sel)
      2'b01:   d = 6'(UART_DIV_38400);
      2'b10:   d = 6'(UART_DIV_57600);
      2'b11:   d = 6'(UART_DIV_115200);
      default: d = 6'd1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO.
// Head reads as zero when empty; pop on empty is ignored.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [LW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rp];
  assign level   = cnt;

  // storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_v1.sv
// uart_rx_v1: 8N1 receiver, 16x oversampling.
// Sync, divider, frame FSM and sticky flags; bytes go to a FWFT FIFO.
module uart_rx_v1
  import uart_rx_v1_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_en,
  input  logic [1:0]                    baud_sel,
  input  logic                          rx,
  input  logic                          rd,
  input  logic                          clr_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam logic [3:0] SC_MID  = 4'(UART_OVS / 2 - 1);
  localparam logic [3:0] SC_LAST = 4'(UART_OVS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  rx_state_e              state_q, state_d;
  logic [3:0]             sc_q, sc_d;
  logic [2:0]             bi_q, bi_d;
  logic [7:0]             sh_q, sh_d;
  logic [1:0]             bsel_q, bsel_d;
  logic [5:0]             div_q;
  logic                   off;
  logic                   tick;
  logic                   push;
  logic                   ferr_set;
  logic                   ovr_set;
  logic                   f_empty;
  logic                   f_full;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign off  = !rx_en || (baud_sel == 2'b00);
  assign tick = !off && (state_q != RX_IDLE)
             && (div_q == div_of(bsel_q) - 6'd1);
  assign busy = (state_q != RX_IDLE);

  // metastability synchronizer, idles high
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  // oversample divider; held at zero in IDLE so sampling
  // phase is taken from the start-bit falling edge
  always_ff @(posedge clk) begin
    if (!rst_n)                           div_q <= '0;
    else if (off || !busy || tick)        div_q <= '0;
    else                                  div_q <= div_q + 6'd1;
  end

  // frame FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      sc_q    <= '0;
      bi_q    <= '0;
      sh_q    <= '0;
      bsel_q  <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      bi_q    <= bi_d;
      sh_q    <= sh_d;
      bsel_q  <= bsel_d;
    end
  end

  // frame FSM next state, push and error strobes
  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bi_d     = bi_q;
    sh_d     = sh_q;
    bsel_d   = bsel_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (off) begin
      state_d = RX_IDLE;
      sc_d    = '0;
      bi_d    = '0;
    end else begin
      unique case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_d = RX_START;
            sc_d    = '0;
            bsel_d  = baud_sel;
          end
        end
        RX_START: begin
          if (tick) begin
            if (sc_q == SC_MID) begin
              sc_d    = '0;
              bi_d    = '0;
              state_d = rx_s ? RX_IDLE : RX_DATA;
            end else begin
              sc_d = sc_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == SC_LAST) begin
              sh_d[bi_q] = rx_s;
              if (bi_q == 3'd7) state_d = RX_STOP;
              else              bi_d    = bi_q + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            sc_d = sc_q + 4'd1;
            if (sc_q == SC_LAST) begin
              if (rx_s) begin
                push    = 1'b1;
                state_d = RX_IDLE;
              end else begin
                ferr_set = 1'b1;
                state_d  = RX_BREAK;
              end
            end
          end
        end
        RX_BREAK: begin
          if (rx_s) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign ovr_set = push && f_full && !rd;

  // sticky error flags; a new event beats clr_err
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovr_set)      overrun   <= 1'b1;
      else if (clr_err) overrun   <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (sh_q),
    .pop   (rd),
    .rdata (rx_data),
    .empty (f_empty),
    .full  (f_full),
    .level (rx_level)
  );

  assign rx_valid = !f_empty;

endmodule

// File: tb/tb_uart_rx_v1.sv
// tb_uart_rx_v1: directed frames with a byte scoreboard.
// Monitor compares rx_data against the queue on every effective rd.
module tb_uart_rx_v1;

  localparam int B115 = 272;
  localparam int B57  = 560;
  localparam int B38  = 832;
  localparam int H115 = 8 * 17;

  logic       clk;
  logic       rst_n;
  logic       rx_en;
  logic [1:0] baud_sel;
  logic       rx;
  logic       rd;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_level;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         n_chk;
  int         n_fail;
  logic [7:0] exp_q[$];

  uart_rx_v1 #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_en     (rx_en),
    .baud_sel  (baud_sel),
    .rx        (rx),
    .rd        (rd),
    .clr_err   (clr_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_level  (rx_level),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: each effective pop is compared
  always @(negedge clk) begin
    if (rst_n && rd && rx_valid) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {24'd0, rx_data}, 32'hffff_ffff);
      end else begin
        check("pop_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_head(input logic [7:0] d, input int b);
    rx = 1'b0;
    cyc(b);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(b);
    end
  endtask

  task automatic send(input logic [7:0] d, input int b, input bit exp);
    if (exp) exp_q.push_back(d);
    send_head(d, b);
    rx = 1'b1;
    cyc(b);
  endtask

  task automatic pop_one();
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rx_en    = 1'b0;
    baud_sel = 2'b00;
    rx       = 1'b1;
    rd       = 1'b0;
    clr_err  = 1'b0;
    cyc(3);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_level", {29'd0, rx_level}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // 115200: single byte, exact push latency
    rx_en    = 1'b1;
    baud_sel = 2'b11;
    cyc(5);
    exp_q.push_back(8'hA5);
    send_head(8'hA5, B115);
    rx = 1'b1;
    cyc(H115 + 2);
    check("lat_pre", {31'd0, rx_valid}, 32'd0);
    cyc(1);
    check("lat_valid", {31'd0, rx_valid}, 32'd1);
    check("lat_data", {24'd0, rx_data}, 32'hA5);
    check("lat_level", {29'd0, rx_level}, 32'd1);
    cyc(B115 - H115 - 3);
    pop_one();
    check("pop_valid0", {31'd0, rx_valid}, 32'd0);
    check("pop_data0", {24'd0, rx_data}, 32'd0);
    pop_one();
    check("rd_empty_lvl", {29'd0, rx_level}, 32'd0);

    // 38400: three back-to-back frames
    baud_sel = 2'b01;
    cyc(5);
    send(8'h00, B38, 1'b1);
    send(8'hFF, B38, 1'b1);
    send(8'h3C, B38, 1'b1);
    cyc(10);
    check("b2b_level", {29'd0, rx_level}, 32'd3);
    check("b2b_flags", {30'd0, frame_err, overrun}, 32'd0);
    repeat (3) pop_one();
    check("b2b_empty", {29'd0, rx_level}, 32'd0);

    // 115200: 100-clock glitch rejected
    baud_sel = 2'b11;
    cyc(5);
    rx = 1'b0;
    cyc(50);
    check("gl_busy1", {31'd0, busy}, 32'd1);
    cyc(50);
    rx = 1'b1;
    cyc(300);
    check("gl_busy0", {31'd0, busy}, 32'd0);
    check("gl_level", {29'd0, rx_level}, 32'd0);
    check("gl_flags", {30'd0, frame_err, overrun}, 32'd0);

    // 57600: framing error followed by a long break
    baud_sel = 2'b10;
    cyc(5);
    send_head(8'h5A, B57);
    rx = 1'b0;
    cyc(B57 / 2 + 10);
    check("fe_set", {31'd0, frame_err}, 32'd1);
    check("fe_level", {29'd0, rx_level}, 32'd0);
    check("fe_busy", {31'd0, busy}, 32'd1);
    pulse_clr();
    cyc(3 * B57);
    check("fe_single", {31'd0, frame_err}, 32'd0);
    check("fe_inbreak", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    cyc(10);
    check("fe_idle", {31'd0, busy}, 32'd0);
    check("fe_level2", {29'd0, rx_level}, 32'd0);
    cyc(B57);
    send(8'h11, B57, 1'b1);
    check("fe_next_ok", {31'd0, frame_err}, 32'd0);
    pop_one();

    // 115200: overrun, then full push with simultaneous rd
    baud_sel = 2'b11;
    cyc(5);
    for (int i = 1; i <= 5; i++) send(8'(i), B115, i <= 4);
    cyc(10);
    check("ov_level", {29'd0, rx_level}, 32'd4);
    check("ov_flag", {31'd0, overrun}, 32'd1);
    check("ov_ferr", {31'd0, frame_err}, 32'd0);
    repeat (4) pop_one();
    pulse_clr();
    check("ov_clr", {31'd0, overrun}, 32'd0);
    for (int i = 1; i <= 4; i++) send(8'(i), B115, 1'b1);
    exp_q.push_back(8'h05);
    send_head(8'h05, B115);
    rx = 1'b1;
    cyc(H115 + 2);
    pop_one();
    check("pr_level", {29'd0, rx_level}, 32'd4);
    check("pr_noovr", {31'd0, overrun}, 32'd0);
    cyc(B115 - H115 - 3);
    repeat (4) pop_one();
    check("pr_empty", {29'd0, rx_level}, 32'd0);

    // reset mid-DATA aborts the frame
    rx = 1'b0;
    cyc(B115);
    rx = 1'b1;
    cyc(B115);
    rx = 1'b0;
    cyc(100);
    check("mr_busy1", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    rx    = 1'b1;
    cyc(2);
    check("mr_busy0", {31'd0, busy}, 32'd0);
    check("mr_valid", {31'd0, rx_valid}, 32'd0);
    check("mr_data", {24'd0, rx_data}, 32'd0);
    check("mr_flags", {30'd0, frame_err, overrun}, 32'd0);
    rst_n = 1'b1;
    cyc(300);
    check("mr_level", {29'd0, rx_level}, 32'd0);
    send(8'hC3, B115, 1'b1);
    pop_one();

    // rx_en dropped mid-frame: frame lost, FIFO kept
    send(8'h77, B115, 1'b1);
    rx = 1'b0;
    cyc(B115);
    rx = 1'b1;
    cyc(200);
    rx_en = 1'b0;
    cyc(3);
    check("en_busy", {31'd0, busy}, 32'd0);
    check("en_level", {29'd0, rx_level}, 32'd1);
    check("en_data", {24'd0, rx_data}, 32'h77);
    cyc(300);
    check("en_level2", {29'd0, rx_level}, 32'd1);
    rx_en = 1'b1;
    cyc(5);
    send(8'hC3, B115, 1'b1);
    check("en_level3", {29'd0, rx_level}, 32'd2);
    repeat (2) pop_one();
    check("en_empty", {29'd0, rx_level}, 32'd0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_v1.md
Name: uart_rx_v1

Overview:
- 8N1 UART receiver for the custom microprocessor's UART peripheral; the receive-side counterpart of the UART transmitter.
- Samples the asynchronous rx pin with 16x oversampling, validates start and stop bits, and buffers received bytes in a small FIFO.
- The CPU register file pops bytes via rd and sees sticky framing/overrun flags.
- Runs on the 32 MHz system clock; baud is selected with the same 2-bit UARTCON encoding as the transmitter.

Parameters:
- FIFO_DEPTH, 4, receive FIFO entries (power of 2, at least 2).
- SYNC_STAGES, 2, flops in the rx input synchronizer.

Ports:
- clk  in  1  32 MHz system clock.
- rst_n  in  1  reset.
- rx_en  in  1  receiver enable (UARTCON bit 6).
- baud_sel  in  2  baud rate (UARTCON bits 5:4): 00 off, 01 38400, 10 57600, 11 115200.
- rx  in  1  asynchronous serial input; idles high.
- rd  in  1  pop one byte from the FIFO; ignored when empty.
- clr_err  in  1  one-cycle pulse that clears frame_err and overrun.
- rx_data  out  8  head of FIFO (first-word-fall-through); 0x00 when empty.
- rx_valid  out  1  FIFO not empty (drives UARTCON RXC).
- rx_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: byte dropped because the FIFO was full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: rst_n is synchronous, active-low. While low:
  - synchronizer flops = 1, FSM = IDLE, all counters = 0, FIFO emptied.
  - rx_data = 0x00, rx_valid = 0, rx_level = 0, frame_err = 0, overrun = 0, busy = 0.
  - Reset mid-frame aborts the frame with no push.
- Oversample tick: one-cycle pulse every DIV clocks. DIV = 52 (01), 35 (10), 17 (11); constants come from defines.v.
  - The divider counter runs 0..DIV-1, ticks at DIV-1, then wraps.
  - baud_sel = 00 or rx_en = 0: no ticks; FSM forced to IDLE the next cycle; any partial frame is discarded. FIFO contents and flags are retained.
  - baud_sel is latched when START is entered and held until the FSM returns to IDLE. Mid-frame changes have no effect on the current frame.
- rx passes through SYNC_STAGES flops before any use (rx_s).
- FSM (4-bit sample counter sc, 3-bit bit index bi), all advancing on ticks only:
  - IDLE: rx_s = 0 -> START, sc = 0, divider cleared. The divider clear aligns sampling to the falling edge.
  - START: at sc = 7 (mid start bit), rx_s = 0 -> DATA with sc = 0, bi = 0; rx_s = 1 -> IDLE (glitch rejected, no flags).
  - DATA: at sc = 15, shift rx_s into shreg LSB-first at index bi. bi = 7 -> STOP, else bi++. sc wraps 15->0.
  - STOP: at sc = 15 (mid stop bit):
    - rx_s = 1 -> push shreg, -> IDLE.
    - rx_s = 0 -> frame_err <= 1, no push, -> BREAK.
  - BREAK: wait for rx_s = 1 (sampled every clock), then -> IDLE. A continuous break yields exactly one frame_err.
- Latency: the pushed byte appears on rx_data, with rx_valid = 1, on the cycle after the stop-bit sample tick when the FIFO was empty.
- FIFO:
  - rd while empty: no effect.
  - Push while full without rd: byte dropped, overrun <= 1.
  - Push and rd in the same cycle while full: both succeed; level stays FIFO_DEPTH; no overrun.
  - Push and rd in the same cycle while empty: the push succeeds, the rd is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Flags:
  - clr_err clears both flags.
  - clr_err in the same cycle as a new error event: the set wins.
  - Flags are not cleared by rx_en.
- busy = (state != IDLE).

Decomposition:
- defines.v holds shared constants:
  - baud divisors UART_DIV_38400 = 52, UART_DIV_57600 = 35, UART_DIV_115200 = 17;
  - UART_OVS = 16;
  - state encodings RX_IDLE/RX_START/RX_DATA/RX_STOP/RX_BREAK.
- One sub-module: uart_rx_fifo, a synchronous FWFT FIFO with push/pop/full/empty/level, parameterised by FIFO_DEPTH and width 8.
- The baud divider, synchronizer, FSM and flags stay in uart_rx_v1.

Test Plan:
- 115200 (bit = 272 clks), rx_en = 1, send 0xA5 -> rx_valid rises 1 cycle after the mid-stop tick, rx_data = 0xA5, rx_level = 1; rd -> rx_valid = 0, rx_data = 0x00.
- 38400 (bit = 832 clks), send 0x00, 0xFF, 0x3C back-to-back -> three pops return 0x00, 0xFF, 0x3C in order; no flags.
- Low glitch of 100 clks at 115200 -> no push, busy returns to 0, no flags.
- 57600, send 0x5A with the stop bit low, then hold rx low for 3 bit times -> frame_err = 1, rx_level = 0, single error; clr_err -> frame_err = 0; next 0x11 received correctly.
- Send 5 bytes 0x01..0x05 without rd -> rx_level = 4, overrun = 1, pops yield 0x01..0x04. Repeat with rd asserted on the 5th push cycle -> no overrun, level stays 4.
- Assert rst_n = 0 mid-DATA of a frame (and separately drop rx_en) -> no push, FSM IDLE, all outputs at reset values (rx_en case: FIFO retained); next frame 0xC3 received correctly.
